// File: rtl/bcd_time_counter.sv
// bcd_time_counter
// ----------------
// BCD time-of-day core. A prescaler divides the clock down to a one-second
// tick. Each accepted tick advances a seconds/minutes/hours chain that is
// stored as 24-hour packed BCD. The hour display is remapped to 12-hour form
// when mode12 is set. One-cycle set pulses step the minutes and the hours.
// A minute-resolution alarm comparator is included.
//
// Ports
//   CLK100MHZ  in  1  clock, all state changes on the rising edge
//   Reset      in  1  synchronous active-high reset
//   run        in  1  1 = prescaler counts, 0 = prescaler holds (no ticks)
//   mode12     in  1  1 = 12-hour display, 0 = 24-hour display
//   MButton    in  1  one-cycle pulse: minutes +1 (no hour carry), clears
//                     the seconds and the prescaler
//   HButton    in  1  one-cycle pulse: hours +1
//   alarm_en   in  1  alarm comparator enable
//   alarm_hrs  in  8  alarm hour, packed BCD, 24-hour form
//   alarm_mins in  8  alarm minute, packed BCD
//   secs_t/secs_u/mins_t/mins_u/hrs_t/hrs_u  out 4  display digits
//   pm         out 1  stored hour is 12..23
//   sec_tick   out 1  one-cycle pulse per accepted second tick
//   alarm_hit  out 1  one-cycle pulse when a tick reaches the alarm time
module bcd_time_counter #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       run,
  input  logic       mode12,
  input  logic       MButton,
  input  logic       HButton,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hrs,
  input  logic [7:0] alarm_mins,
  output logic [3:0] secs_t,
  output logic [3:0] secs_u,
  output logic [3:0] mins_t,
  output logic [3:0] mins_u,
  output logic [3:0] hrs_t,
  output logic [3:0] hrs_u,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_hit
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Packed BCD increment with wrap to 00 after the value 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       secs_reg, secs_next;
  logic [7:0]       mins_reg, mins_next;
  logic [7:0]       hrs_reg, hrs_next;
  logic             sec_tick_reg, alarm_hit_reg;

  logic tick;
  logic accept;
  logic secs_wrap, mins_wrap;
  logic alarm_match;

  always_comb begin
    tick      = run && (count_reg == CNT_LAST);
    // A tick that coincides with either set pulse is dropped.
    accept    = tick && !MButton && !HButton;
    secs_wrap = (secs_reg == 8'h59);
    mins_wrap = (mins_reg == 8'h59);

    count_next = count_reg;
    if (MButton) begin
      count_next = '0;
    end else if (run) begin
      count_next = tick ? '0 : count_reg + CNT_ONE;
    end

    secs_next = secs_reg;
    mins_next = mins_reg;
    hrs_next  = hrs_reg;

    if (MButton) begin
      secs_next = 8'h00;
      mins_next = bcd_inc(mins_reg, 8'h59);
    end else if (accept) begin
      secs_next = bcd_inc(secs_reg, 8'h59);
      if (secs_wrap) begin
        mins_next = bcd_inc(mins_reg, 8'h59);
      end
    end

    if (HButton || (accept && secs_wrap && mins_wrap)) begin
      hrs_next = bcd_inc(hrs_reg, 8'h23);
    end

    // Compared against the post-tick time so the pulse lines up with sec_tick.
    // Set edits never qualify because accept excludes them; illegal alarm
    // values can never equal the always-legal stored time.
    alarm_match = accept && alarm_en &&
                  ({hrs_next, mins_next, secs_next} == {alarm_hrs, alarm_mins, 8'h00});
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      count_reg     <= '0;
      secs_reg      <= 8'h00;
      mins_reg      <= 8'h00;
      hrs_reg       <= 8'h00;
      sec_tick_reg  <= 1'b0;
      alarm_hit_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      secs_reg      <= secs_next;
      mins_reg      <= mins_next;
      hrs_reg       <= hrs_next;
      sec_tick_reg  <= accept;
      alarm_hit_reg <= alarm_match;
    end
  end

  // Display mapping: purely combinational from the stored 24-hour value.
  logic [4:0] hr_bin;
  logic [4:0] hr12;
  logic [4:0] hr12_less10;

  always_comb begin
    hr_bin = ({1'b0, hrs_reg[7:4]} * 5'd10) + {1'b0, hrs_reg[3:0]};
    pm     = (hr_bin >= 5'd12);

    if (hr_bin == 5'd0) begin
      hr12 = 5'd12;
    end else if (hr_bin > 5'd12) begin
      hr12 = hr_bin - 5'd12;
    end else begin
      hr12 = hr_bin;
    end
    hr12_less10 = hr12 - 5'd10;

    if (mode12) begin
      if (hr12 >= 5'd10) begin
        hrs_t = 4'd1;
        hrs_u = hr12_less10[3:0];
      end else begin
        hrs_t = 4'd0;
        hrs_u = hr12[3:0];
      end
    end else begin
      hrs_t = hrs_reg[7:4];
      hrs_u = hrs_reg[3:0];
    end
  end

  assign secs_t    = secs_reg[7:4];
  assign secs_u    = secs_reg[3:0];
  assign mins_t    = mins_reg[7:4];
  assign mins_u    = mins_reg[3:0];
  assign sec_tick  = sec_tick_reg;
  assign alarm_hit = alarm_hit_reg;

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b0, run = 1'b0, mode12 = 1'b0;
  logic       MButton = 1'b0, HButton = 1'b0, alarm_en = 1'b0;
  logic [7:0] alarm_hrs = 8'h07, alarm_mins = 8'h30;
  logic [3:0] secs_t, secs_u, mins_t, mins_u, hrs_t, hrs_u;
  logic       pm, sec_tick, alarm_hit;

  always #5 clk = ~clk;

  bcd_time_counter #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
    .CLK100MHZ(clk), .Reset(Reset), .run(run), .mode12(mode12),
    .MButton(MButton), .HButton(HButton), .alarm_en(alarm_en),
    .alarm_hrs(alarm_hrs), .alarm_mins(alarm_mins),
    .secs_t(secs_t), .secs_u(secs_u), .mins_t(mins_t), .mins_u(mins_u),
    .hrs_t(hrs_t), .hrs_u(hrs_u), .pm(pm), .sec_tick(sec_tick),
    .alarm_hit(alarm_hit)
  );

  typedef struct {
    int h;
    int m;
    int s;
    bit tick;
    bit alarm;
  } exp_t;

  exp_t exp_q[$];
  int   mh = 0, mm = 0, ms = 0, mcnt = 0;
  int   ah = 7, am = 30;
  int   checks = 0, errors = 0;

  // Expected display word {hrs_t, hrs_u, mins_t, mins_u, secs_t, secs_u, pm}.
  function automatic logic [24:0] disp_word(input int h, input int m, input int s, input bit m12);
    int dh;
    logic p;
    p  = (h >= 12);
    dh = h;
    if (m12) begin
      if (h == 0) dh = 12;
      else if (h > 12) dh = h - 12;
    end
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p};
  endfunction

  function automatic logic [24:0] dut_word();
    return {hrs_t, hrs_u, mins_t, mins_u, secs_t, secs_u, pm};
  endfunction

  // Drive one cycle, advance the reference model, push its expectation.
  task automatic step(input bit mb, input bit hb, input bit rst);
    bit   tk, acc;
    exp_t e;
    MButton = mb;
    HButton = hb;
    Reset   = rst;
    if (rst) begin
      mh = 0; mm = 0; ms = 0; mcnt = 0; acc = 1'b0;
    end else begin
      tk = run && (mcnt == TPS - 1);
      if (mb) mcnt = 0;
      else if (run) mcnt = tk ? 0 : mcnt + 1;
      acc = tk && !mb && !hb;
      if (mb) begin
        mm = (mm + 1) % 60;
        ms = 0;
      end
      if (hb) mh = (mh + 1) % 24;
      if (acc) begin
        ms++;
        if (ms == 60) begin
          ms = 0;
          mm++;
          if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
          end
        end
      end
    end
    e.h = mh; e.m = mm; e.s = ms; e.tick = acc;
    e.alarm = acc && alarm_en && (mh == ah) && (mm == am) && (ms == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    MButton = 1'b0;
    HButton = 1'b0;
    Reset   = 1'b0;
  endtask

  // Reset, then set hh:mm:00 with the prescaler halted.
  task automatic preload(input int h, input int m);
    run = 1'b0;
    step(0, 0, 1);
    repeat (h) step(0, 1, 0);
    repeat (m) step(1, 0, 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    run = 1'b1; mode12 = 1'b0; alarm_en = 1'b1;
    step(0, 0, 0);
    step(1, 1, 1);
    exp_q.delete();
    checks++;
    if (dut_word() !== 25'd0 || sec_tick !== 1'b0 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset24: got %h st=%b ah=%b want 0000000 st=0 ah=0", dut_word(), sec_tick, alarm_hit);
    end
    mode12 = 1'b1;
    #1;
    checks++;
    if (dut_word() !== {4'd1, 4'd2, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset12: got %h want %h", dut_word(), {4'd1, 4'd2, 16'd0, 1'b0});
    end
    mode12 = 1'b0;
    alarm_en = 1'b0;
    $display("reset: digits %h", dut_word());
  endtask

  task automatic test_tick_period();
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== e.tick || alarm_hit !== e.alarm) begin
        errors++;
        $display("FAIL tick_model k=%0d: got %h st=%b want %h st=%b", k, dut_word(), sec_tick,
                 disp_word(e.h, e.m, e.s, mode12), e.tick);
      end
      checks++;
      if (sec_tick !== ((k % TPS) == 0)) begin
        errors++;
        $display("FAIL tick_period k=%0d: sec_tick=%b want %b", k, sec_tick, (k % TPS) == 0);
      end
      if (k == TPS) begin
        checks++;
        if ({secs_t, secs_u} !== 8'h01) begin
          errors++;
          $display("FAIL first_tick_secs: got %h want 01", {secs_t, secs_u});
        end
      end
    end
    $display("tick_period: after 16 cycles secs=%h", {secs_t, secs_u});
  endtask

  task automatic test_wrap();
    exp_t e;
    int   ticks = 0, hits = 0;
    preload(23, 59);
    alarm_en = 1'b1;
    run = 1'b1;
    for (int n = 0; n < 400 && ticks < 60; n++) begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== e.tick || alarm_hit !== e.alarm) begin
        errors++;
        $display("FAIL wrap_model n=%0d: got %h st=%b want %h st=%b", n, dut_word(), sec_tick,
                 disp_word(e.h, e.m, e.s, mode12), e.tick);
      end
      if (alarm_hit === 1'b1) hits++;
      if (sec_tick === 1'b1) begin
        ticks++;
        if (ticks == 59) begin
          checks++;
          if (dut_word() !== {4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL wrap_235959: got %h", dut_word());
          end
        end
        if (ticks == 60) begin
          checks++;
          if (dut_word() !== 25'd0) begin
            errors++;
            $display("FAIL wrap_000000: got %h want 0000000", dut_word());
          end
        end
      end
    end
    checks++;
    if (ticks != 60 || hits != 0) begin
      errors++;
      $display("FAIL wrap_counts: ticks=%0d hits=%0d want 60 and 0", ticks, hits);
    end
    alarm_en = 1'b0;
    $display("wrap: time %h ticks=%0d", dut_word(), ticks);
  endtask

  task automatic test_mbutton();
    exp_t e;
    int   k;
    preload(10, 59);
    run = 1'b1;
    for (int n = 0; n < 200 && ms != 30; n++) begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== e.tick) begin
        errors++;
        $display("FAIL mb_run n=%0d: got %h want %h", n, dut_word(), disp_word(e.h, e.m, e.s, mode12));
      end
    end
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    exp_q.delete();
    checks++;
    if (dut_word() !== {4'd1, 4'd0, 16'd0, 1'b0} || sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL mb_edit: got %h st=%b want 1000000 st=0", dut_word(), sec_tick);
    end
    k = 0;
    do begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      k++;
    end while (sec_tick !== 1'b1 && k < 10);
    checks++;
    if (k != TPS || {hrs_t, hrs_u, mins_t, mins_u, secs_t, secs_u} !== 24'h100001) begin
      errors++;
      $display("FAIL mb_next_tick: after %0d cycles time %h want %0d cycles 10:00:01", k, dut_word(), TPS);
    end
    $display("mbutton: next tick after %0d cycles", k);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    preload(5, 20);
    run = 1'b1;
    for (int n = 0; n < 100 && !(ms == 10 && mcnt == TPS - 1); n++) begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== e.tick) begin
        errors++;
        $display("FAIL b2b_run n=%0d: got %h want %h", n, dut_word(), disp_word(e.h, e.m, e.s, mode12));
      end
    end
    step(1, 1, 0);
    e = exp_q.pop_front();
    checks++;
    if (dut_word() !== {4'd0, 4'd6, 4'd2, 4'd1, 4'd0, 4'd0, 1'b0} || sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL b2b_edit: got %h st=%b want 06:21:00 st=0", dut_word(), sec_tick);
    end
    $display("back_to_back: time %h", dut_word());
  endtask

  task automatic test_mode12();
    preload(0, 15);
    mode12 = 1'b1;
    #1;
    checks++;
    if ({hrs_t, hrs_u, mins_t, mins_u, pm} !== {16'h1215, 1'b0}) begin
      errors++;
      $display("FAIL m12_0015: got %h%h:%h%h pm=%b want 12:15 pm=0", hrs_t, hrs_u, mins_t, mins_u, pm);
    end
    repeat (50) step(1, 0, 0);
    repeat (13) step(0, 1, 0);
    exp_q.delete();
    checks++;
    if ({hrs_t, hrs_u, mins_t, mins_u, pm} !== {16'h0105, 1'b1}) begin
      errors++;
      $display("FAIL m12_1305: got %h%h:%h%h pm=%b want 01:05 pm=1", hrs_t, hrs_u, mins_t, mins_u, pm);
    end
    mode12 = 1'b0;
    #1;
    checks++;
    if ({hrs_t, hrs_u, mins_t, mins_u, pm} !== {16'h1305, 1'b1}) begin
      errors++;
      $display("FAIL m24_1305: got %h%h:%h%h pm=%b want 13:05 pm=1", hrs_t, hrs_u, mins_t, mins_u, pm);
    end
    repeat (23) step(0, 1, 0);
    repeat (55) step(1, 0, 0);
    exp_q.delete();
    mode12 = 1'b1;
    #1;
    checks++;
    if ({hrs_t, hrs_u, mins_t, mins_u, pm} !== {16'h1200, 1'b1}) begin
      errors++;
      $display("FAIL m12_1200: got %h%h:%h%h pm=%b want 12:00 pm=1", hrs_t, hrs_u, mins_t, mins_u, pm);
    end
    mode12 = 1'b0;
    $display("mode12: display %h", dut_word());
  endtask

  task automatic test_alarm();
    exp_t e;
    int   hits;
    // Enabled: 07:29:00 -> 07:30:00 via ticks.
    for (int pass = 0; pass < 2; pass++) begin
      preload(7, 29);
      alarm_en = (pass == 0);
      run = 1'b1;
      hits = 0;
      for (int n = 0; n < 250; n++) begin
        step(0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== e.tick || alarm_hit !== e.alarm) begin
          errors++;
          $display("FAIL alarm_model p=%0d n=%0d: got %h st=%b ah=%b want %h st=%b ah=%b", pass, n,
                   dut_word(), sec_tick, alarm_hit, disp_word(e.h, e.m, e.s, mode12), e.tick, e.alarm);
        end
        if (alarm_hit === 1'b1) begin
          hits++;
          checks++;
          if (sec_tick !== 1'b1 || dut_word() !== {4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL alarm_when: time %h st=%b want 07:30:00 st=1", dut_word(), sec_tick);
          end
        end
      end
      checks++;
      if (hits != ((pass == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL alarm_count en=%0d: hits=%0d want %0d", alarm_en, hits, (pass == 0) ? 1 : 0);
      end
      $display("alarm: en=%0d hits=%0d", alarm_en, hits);
    end

    // Reaching 07:30 by a set pulse must not fire.
    alarm_en = 1'b1;
    preload(7, 29);
    step(1, 0, 0);
    run = 1'b1;
    hits = 0;
    for (int n = 0; n < 20; n++) begin
      step(0, 0, 0);
      if (alarm_hit === 1'b1) hits++;
    end
    exp_q.delete();
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL alarm_mbutton: hits=%0d want 0", hits);
    end

    // Reset mid-count overrides concurrent pulses.
    mode12 = 1'b1;
    step(0, 0, 0);
    step(1, 1, 1);
    e = exp_q.pop_back();
    exp_q.delete();
    checks++;
    if (dut_word() !== {4'd1, 4'd2, 16'd0, 1'b0} || sec_tick !== 1'b0 || alarm_hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h st=%b ah=%b want 1200000 st=0 ah=0", dut_word(), sec_tick, alarm_hit);
    end
    mode12 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dut_word() !== disp_word(e.h, e.m, e.s, mode12) || sec_tick !== ((k % TPS) == 0)) begin
        errors++;
        $display("FAIL post_reset k=%0d: got %h st=%b want %h st=%b", k, dut_word(), sec_tick,
                 disp_word(e.h, e.m, e.s, mode12), (k % TPS) == 0);
      end
    end
    $display("alarm: post-reset time %h", dut_word());
  endtask

  initial begin
    #1;
    test_reset();
    test_tick_period();
    test_wrap();
    test_mbutton();
    test_back_to_back();
    test_mode12();
    test_alarm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised BCD time-of-day core for the wall-clock design: a prescaler divides `CLK100MHZ` down to a one-second tick, and the tick drives a seconds/minutes/hours BCD chain. Hours run in 24-hour or 12-hour display mode, selectable at run time. Debounced set pulses step minutes and hours, and a minute-resolution alarm comparator is included. Its digit outputs feed `SS_Driver` directly, replacing the ad-hoc counter logic in the top level.

## Interface
- `TICKS_PER_SEC`, 100000000: clock cycles per second; minimum 2.
- `CNT_W`, 27: prescaler width; requires 2^CNT_W > TICKS_PER_SEC-1.

Ports:
- `CLK100MHZ` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `run` in 1: 1 = prescaler counts; 0 = prescaler holds and no ticks are generated.
- `mode12` in 1: 1 = 12-hour display, 0 = 24-hour display.
- `MButton` in 1: one-cycle debounced pulse; set minutes.
- `HButton` in 1: one-cycle debounced pulse; set hours.
- `alarm_en` in 1: enables the alarm comparator.
- `alarm_hrs` in 8: alarm hour, packed BCD {tens, units}, always 24-hour form (00–23).
- `alarm_mins` in 8: alarm minute, packed BCD (00–59).
- `secs_t`, `secs_u`, `mins_t`, `mins_u`, `hrs_t`, `hrs_u` out 4 each: BCD display digits.
- `pm` out 1: 1 when the stored hour is 12–23; valid in both modes.
- `sec_tick` out 1: one-cycle pulse on each accepted second tick.
- `alarm_hit` out 1: one-cycle alarm pulse.

## Operation
- Prescaler `Count` (CNT_W bits):
  - When `run`=1, increments each cycle.
  - At TICKS_PER_SEC-1 it wraps to 0 and raises the internal tick.
  - When `run`=0, `Count` holds and no tick is generated.
- Time state is stored as 24-hour BCD: secs 00–59, mins 00–59, hrs 00–23.
  - Digits never hold illegal BCD values (A–F) or out-of-range values.
- Tick chain:
  - secs +1.
  - 59→00 carries into mins.
  - mins 59→00 carries into hrs.
  - hrs 23→00; no day output.
- `MButton`:
  - mins +1, wrapping 59→00 with NO carry into hrs.
  - secs cleared to 00.
  - `Count` cleared to 0.
- `HButton`: hrs +1, wrapping 23→00; mins, secs and `Count` are unaffected.
- Priority, highest first: `Reset` > set pulses > tick.
  - A tick arriving in a cycle with either set pulse is discarded: no secs advance, no `sec_tick`.
  - `Count` still wraps normally unless `MButton` clears it.
- `MButton` and `HButton` in the same cycle: both edits are applied independently.
- Display mapping is a combinational function of the stored state (no added latency):
  - 24-hour mode: `hrs_t`/`hrs_u` equal the stored hour.
  - 12-hour mode: stored 00 → 12 with `pm`=0; 01–11 → 01–11 with `pm`=0; 12 → 12 with `pm`=1; 13–23 → 01–11 with `pm`=1.
  - Toggling `mode12` changes only the display; stored time is unchanged.
- Alarm:
  - `alarm_hit`=1 for exactly one cycle on the cycle after an accepted tick that makes the stored time equal {`alarm_hrs`, `alarm_mins`, 00}, provided `alarm_en`=1 at that tick.
  - Set-pulse edits never fire the alarm.
  - Out-of-range alarm values never match.

## Timing
- Reset values: `Count`=0; time 00:00:00.
  - Outputs in 24-hour mode: all digits 0, `pm`=0, `sec_tick`=0, `alarm_hit`=0.
  - Outputs in 12-hour mode: `hrs_t`=1, `hrs_u`=2, other digits 0, `pm`=0.
- Reset mid-operation clears everything on the next edge; it overrides any concurrent pulse or tick.
- Latency: the tick is generated at the edge where `Count`=TICKS_PER_SEC-1.
  - New secs and `sec_tick`=1 are visible in the following cycle.
  - Period between `sec_tick` pulses is exactly TICKS_PER_SEC cycles while `run`=1 and no `MButton` occurs.
- After `MButton`, the next tick arrives exactly TICKS_PER_SEC cycles later.
- Set-pulse edits are visible on outputs one cycle after the pulse.
- `alarm_hit` is coincident with the `sec_tick` for the matching second.

## Test plan
- Reset, `TICKS_PER_SEC`=4, `run`=1 → first `sec_tick` in the 4th cycle after reset release; secs=01; subsequent ticks every 4 cycles.
- Preload to 23:59:58 via set pulses plus ticks, then apply 2 ticks → 23:59:59, then 00:00:00; no spurious `alarm_hit`.
- From 10:59:30, pulse `MButton` → 10:00:00 (no hour carry); `Count`=0; next tick exactly 4 cycles later.
- `MButton` and `HButton` in the same cycle as a tick, from 05:20:10 → 06:21:00; no `sec_tick` that cycle.
- `mode12`=1 at stored 00:15 → display 12:15 with `pm`=0; at 13:05 → 01:05 with `pm`=1; at 12:00 → 12:00 with `pm`=1; toggle back to 24-hour mode → 13:05 unchanged.
- `alarm_en`=1, alarm 07:30, tick 07:29:59→07:30:00 → `alarm_hit` pulses one cycle.
  - With `alarm_en`=0 → no pulse.
  - Reaching 07:30 via `MButton` → no pulse.
  - Assert `Reset` mid-sequence → all outputs return to their reset values next cycle.
